// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline hazard/forwarding logic.
//   REG_ADDR_W    : register index width (R0-R15)
//   stage_entry_t : per-stage tracker entry {dest, wbe, mem_read}
//   fwd_sel_e     : forwarding mux select encodings shared with the forwarding unit
//   src_match     : RAW match of the ID-stage sources against one stage entry
package arm_pipe_pkg;

    localparam int REG_ADDR_W = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  wbe;
        logic                  mem_read;
    } stage_entry_t;

    typedef enum logic [1:0] {
        FWD_SEL_RF  = 2'b00,
        FWD_SEL_MEM = 2'b01,
        FWD_SEL_WB  = 2'b10
    } fwd_sel_e;

    // A stale destination with wbe = 0 never matches; src_2 only counts when it is read.
    function automatic logic src_match(
        input stage_entry_t          entry,
        input logic [REG_ADDR_W-1:0] src_1,
        input logic [REG_ADDR_W-1:0] src_2,
        input logic                  two_src
    );
        return entry.wbe && ((src_1 == entry.dest) || (two_src && (src_2 == entry.dest)));
    endfunction

endpackage

// File: rtl/wbt_stage_reg.sv
// One tracker stage register.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, clears the entry
//   hold   : keep the current entry (pipeline freeze); takes priority over bubble
//   bubble : load an empty entry {0,0,0} instead of d
//   d      : entry arriving from the previous stage
//   q      : entry currently held by this stage
module wbt_stage_reg
    import arm_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         bubble,
    input  stage_entry_t d,
    output stage_entry_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (!hold) begin
            q <= bubble ? stage_entry_t'('0) : d;
        end
    end

endmodule

// File: rtl/writeback_tracker.sv
// Tracks destination register / write-back enable of in-flight instructions
// through EX, MEM and WB, and produces the ID-stage hazard stall.
//   i_Clk, i_Reset                : clock, asynchronous active-high reset
//   i_Forwarding_Enable           : 1 = stall on load-use only, 0 = stall on any EX/MEM RAW
//   i_Freeze                      : hold all tracker state and the stall counter
//   i_Flush                       : kill the ID-stage instruction (bubble into EX, no stall)
//   i_Id_*, i_Src_*, i_Two_Src    : ID-stage instruction description
//   o_Exe_*, o_Memory_*, o_Write_Back_* : per-stage destination / write-back enable
//   o_Hazard_Stall                : combinational stall for PC and IF/ID, bubble into EX
//   o_Stall_Count                 : saturating count of non-frozen stall cycles
//
// Flow control: the ID instruction moves into EX on a non-frozen edge only when
// it is valid, not flushed and not stalled; o_Hazard_Stall is the "not ready"
// back to ID, and every rejected slot becomes a bubble with wbe = 0.
module writeback_tracker
    import arm_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Forwarding_Enable,
    input  logic                   i_Freeze,
    input  logic                   i_Flush,
    input  logic                   i_Id_Valid,
    input  logic [REG_ADDR_W-1:0]  i_Src_1,
    input  logic [REG_ADDR_W-1:0]  i_Src_2,
    input  logic                   i_Two_Src,
    input  logic [REG_ADDR_W-1:0]  i_Id_Destination,
    input  logic                   i_Id_Write_Back_Enable,
    input  logic                   i_Id_Mem_Read,
    output logic [REG_ADDR_W-1:0]  o_Exe_Destination,
    output logic                   o_Sig_Exe_Write_Back_Enable,
    output logic [REG_ADDR_W-1:0]  o_Memory_Destination,
    output logic                   o_Sig_Memory_Write_Back_Enable,
    output logic [REG_ADDR_W-1:0]  o_Write_Back_Destination,
    output logic                   o_Sig_Write_Back_Write_Back_Enable,
    output logic                   o_Hazard_Stall,
    output logic [STALL_CNT_W-1:0] o_Stall_Count
);

    stage_entry_t exe_q, mem_q, wb_q, id_entry;
    logic         m_exe, m_mem, base, hazard, exe_bubble;
    logic         unused_wb_mem_read;

    assign id_entry = '{dest: i_Id_Destination, wbe: i_Id_Write_Back_Enable, mem_read: i_Id_Mem_Read};

    assign m_exe = src_match(exe_q, i_Src_1, i_Src_2, i_Two_Src);
    assign m_mem = src_match(mem_q, i_Src_1, i_Src_2, i_Two_Src);

    // Flush beats any match. WB matches never stall: the register file is
    // written in the first half-cycle and read in the second.
    assign base   = i_Id_Valid && !i_Flush;
    assign hazard = i_Forwarding_Enable ? (base && m_exe && exe_q.mem_read)
                                        : (base && (m_exe || m_mem));
    assign exe_bubble = !(i_Id_Valid && !hazard && !i_Flush);

    wbt_stage_reg u_exe (
        .clk    (i_Clk),
        .rst    (i_Reset),
        .hold   (i_Freeze),
        .bubble (exe_bubble),
        .d      (id_entry),
        .q      (exe_q)
    );

    wbt_stage_reg u_mem (
        .clk    (i_Clk),
        .rst    (i_Reset),
        .hold   (i_Freeze),
        .bubble (1'b0),
        .d      (exe_q),
        .q      (mem_q)
    );

    wbt_stage_reg u_wb (
        .clk    (i_Clk),
        .rst    (i_Reset),
        .hold   (i_Freeze),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    // Load flag is meaningless once an instruction reaches WB.
    assign unused_wb_mem_read = wb_q.mem_read;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Stall_Count <= '0;
        end else if (hazard && !i_Freeze && (o_Stall_Count != '1)) begin
            o_Stall_Count <= o_Stall_Count + STALL_CNT_W'(1);
        end
    end

    assign o_Hazard_Stall                     = hazard;
    assign o_Exe_Destination                  = exe_q.dest;
    assign o_Sig_Exe_Write_Back_Enable        = exe_q.wbe;
    assign o_Memory_Destination               = mem_q.dest;
    assign o_Sig_Memory_Write_Back_Enable     = mem_q.wbe;
    assign o_Write_Back_Destination           = wb_q.dest;
    assign o_Sig_Write_Back_Write_Back_Enable = wb_q.wbe;

endmodule

// File: tb/tb_writeback_tracker.sv
// Bench for writeback_tracker: a 16-bit-counter instance and a 2-bit-counter
// instance share all stimulus. Expected stage entries {dest, wbe, mem_read}
// are queued as each ID slot is driven and popped as they reach WB.
module tb_writeback_tracker;
    import arm_pipe_pkg::*;

    localparam int AW = REG_ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0, fwd = 1'b0, freeze = 1'b0, flush = 1'b0;
    logic          id_valid = 1'b0, two_src = 1'b0, id_wbe = 1'b0, id_mr = 1'b0;
    logic [AW-1:0] src1 = '0, src2 = '0, id_dst = '0;

    logic [AW-1:0] exe_dst, mem_dst, wb_dst, s_exe_dst, s_mem_dst, s_wb_dst;
    logic          exe_wbe, mem_wbe, wb_wbe, stall;
    logic          s_exe_wbe, s_mem_wbe, s_wb_wbe, s_stall;
    logic [15:0]   cnt;
    logic [1:0]    cnt_sat;

    writeback_tracker #(.STALL_CNT_W(16)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Forwarding_Enable(fwd), .i_Freeze(freeze),
        .i_Flush(flush), .i_Id_Valid(id_valid), .i_Src_1(src1), .i_Src_2(src2),
        .i_Two_Src(two_src), .i_Id_Destination(id_dst),
        .i_Id_Write_Back_Enable(id_wbe), .i_Id_Mem_Read(id_mr),
        .o_Exe_Destination(exe_dst), .o_Sig_Exe_Write_Back_Enable(exe_wbe),
        .o_Memory_Destination(mem_dst), .o_Sig_Memory_Write_Back_Enable(mem_wbe),
        .o_Write_Back_Destination(wb_dst), .o_Sig_Write_Back_Write_Back_Enable(wb_wbe),
        .o_Hazard_Stall(stall), .o_Stall_Count(cnt)
    );

    writeback_tracker #(.STALL_CNT_W(2)) dut_sat (
        .i_Clk(clk), .i_Reset(rst), .i_Forwarding_Enable(fwd), .i_Freeze(freeze),
        .i_Flush(flush), .i_Id_Valid(id_valid), .i_Src_1(src1), .i_Src_2(src2),
        .i_Two_Src(two_src), .i_Id_Destination(id_dst),
        .i_Id_Write_Back_Enable(id_wbe), .i_Id_Mem_Read(id_mr),
        .o_Exe_Destination(s_exe_dst), .o_Sig_Exe_Write_Back_Enable(s_exe_wbe),
        .o_Memory_Destination(s_mem_dst), .o_Sig_Memory_Write_Back_Enable(s_mem_wbe),
        .o_Write_Back_Destination(s_wb_dst), .o_Sig_Write_Back_Write_Back_Enable(s_wb_wbe),
        .o_Hazard_Stall(s_stall), .o_Stall_Count(cnt_sat)
    );

    // ---------------- scoreboard ----------------
    logic [5:0]  exp_q[$];   // [0] = expected MEM entry, [1] = expected EX entry
    logic [5:0]  last_wb;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt_sat;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_match(input logic [5:0] e);
        return e[1] && ((src1 == e[5:2]) || (two_src && (src2 == e[5:2])));
    endfunction

    function automatic logic model_stall();
        logic b;
        b = id_valid && !flush;
        if (fwd) return b && model_match(exp_q[1]) && exp_q[1][0];
        return b && (model_match(exp_q[1]) || model_match(exp_q[0]));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_outputs", {exe_dst, exe_wbe, mem_dst, mem_wbe, wb_dst, wb_wbe, stall}, 0);
        check("reset_count", cnt, 0);
        check("reset_sat", {s_exe_wbe, s_mem_wbe, s_wb_wbe, s_stall, cnt_sat}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q = {6'd0, 6'd0};
        last_wb = '0;
        exp_cnt = '0;
        exp_cnt_sat = '0;
    endtask

    // One ID slot: drive, check the combinational stall, clock, check stages.
    // exp_stall < 0 means no directed expectation for the stall in this slot.
    task automatic cycle(input int v, input int s1, input int s2, input int two,
                         input int dst, input int wbe, input int mr,
                         input int fl, input int frz, input int exp_stall);
        logic exp_s;
        id_valid = v[0]; src1 = s1[AW-1:0]; src2 = s2[AW-1:0]; two_src = two[0];
        id_dst = dst[AW-1:0]; id_wbe = wbe[0]; id_mr = mr[0]; flush = fl[0]; freeze = frz[0];
        #1;
        exp_s = model_stall();
        check("hazard_stall", stall, exp_s);
        check("hazard_stall_sat", s_stall, exp_s);
        if (exp_stall >= 0) check("hazard_stall_directed", stall, exp_stall[0]);
        @(posedge clk);
        #1;
        if (!freeze) begin
            exp_q.push_back((id_valid && !flush && !exp_s) ? {id_dst, id_wbe, id_mr} : 6'd0);
            last_wb = exp_q.pop_front();
            if (exp_s) begin
                if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
                if (exp_cnt_sat != 2'b11) exp_cnt_sat = exp_cnt_sat + 2'd1;
            end
        end
        check("exe_entry", {exe_dst, exe_wbe}, exp_q[1][5:1]);
        check("mem_entry", {mem_dst, mem_wbe}, exp_q[0][5:1]);
        check("wb_entry", {wb_dst, wb_wbe}, last_wb[5:1]);
        check("sat_entries", {s_exe_dst, s_exe_wbe, s_mem_dst, s_mem_wbe, s_wb_dst, s_wb_wbe},
              {exp_q[1][5:1], exp_q[0][5:1], last_wb[5:1]});
        check("stall_count", cnt, exp_cnt);
        check("stall_count_sat", cnt_sat, exp_cnt_sat);
    endtask

    // ---------------- stimulus ----------------
    int          sat_tab[5] = '{1, 2, 3, 3, 3};
    logic [15:0] cnt_before;

    initial begin
        #2;
        do_reset();

        // Reset mid-stream with live EX/MEM entries and a stall in progress.
        fwd = 1'b0;
        cycle(1, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        cycle(1, 6, 0, 0, 9, 1, 0, 0, 0, 1);
        check("pre_reset_count", cnt, 1);
        #2;
        do_reset();

        // Forwarding off: RAW on R3 stalls while R3 is in EX and in MEM.
        fwd = 1'b0;
        cycle(1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        cycle(1, 3, 0, 0, 7, 1, 0, 0, 0, 1);
        cycle(1, 3, 0, 0, 7, 1, 0, 0, 0, 1);
        check("bubble_mem_wbe", mem_wbe, 0);
        cycle(1, 3, 0, 0, 7, 1, 0, 0, 0, 0);
        check("raw_stall_count", cnt, 2);

        // Forwarding on: load-use via src_2, then src_2 ignored when not read.
        do_reset();
        fwd = 1'b1;
        cycle(1, 0, 0, 0, 4, 1, 1, 0, 0, 0);
        cycle(1, 0, 4, 1, 8, 1, 0, 0, 0, 1);
        cycle(1, 0, 4, 1, 8, 1, 0, 0, 0, 0);
        check("load_use_count", cnt, 1);
        cycle(1, 0, 0, 0, 4, 1, 1, 0, 0, 0);
        cycle(1, 9, 4, 0, 8, 1, 0, 0, 0, 0);
        check("two_src_off_count", cnt, 1);

        // Forwarding on: ALU result is forwarded, no stall.
        cycle(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        cycle(1, 5, 0, 0, 10, 1, 0, 0, 0, 0);
        check("mem_dest_fwd", {mem_dst, mem_wbe}, {4'd5, 1'b1});
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wb_dest_fwd", {wb_dst, wb_wbe}, {4'd5, 1'b1});

        // Flush beats a hazard match, then freeze holds everything.
        fwd = 1'b0;
        cycle(1, 0, 0, 0, 11, 1, 0, 0, 0, 0);
        cycle(1, 11, 0, 0, 12, 1, 0, 1, 0, 0);
        check("flush_bubble_exe_wbe", exe_wbe, 0);
        cnt_before = exp_cnt;
        for (int i = 0; i < 3; i++) cycle(1, 11, 0, 0, 12, 1, 0, 0, 1, 1);
        check("freeze_mem_dest", {mem_dst, mem_wbe}, {4'd11, 1'b1});
        check("freeze_count", cnt, cnt_before);
        freeze = 1'b0;

        // Saturation of the 2-bit counter across five load-use stalls.
        do_reset();
        fwd = 1'b1;
        cycle(1, 0, 0, 0, 4, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 4, 0, 0, 4, 1, 1, 0, 0, 1);
            check("sat_count_seq", cnt_sat, sat_tab[i]);
            check("wide_count_seq", cnt, i + 1);
            cycle(1, 4, 0, 0, 4, 1, 1, 0, 0, 0);
        end

        // Random traffic over a small register range to provoke hazards.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            fwd = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
